// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the iterative InvSubBytes stage.
// The master drives input-side data; the slave is the stage itself.
interface inv_sub_bytes_seq_if;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: LANES bytes per cycle, valid/ready on both sides.
// Optional macro INV_SUB_ADDKEY_EN fuses AddRoundKey into the output register.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    inv_sub_bytes_seq_if.slave  bus,
`ifdef INV_SUB_ADDKEY_EN
    input  logic [127:0]        round_key,
`endif
    output logic                busy
);

    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    // Only power-of-two lane counts divide the state evenly.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
              LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_work;
    logic [127:0]   r_out;
    logic           r_ovalid;
    logic [127:0]   r_key;
    logic           w_accept;
    logic           w_fire;
    logic           w_last;
    logic           w_in_ready;
    logic           w_busy;
    logic [7:0]     w_lane_in  [LANES];
    logic [7:0]     w_lane_out [LANES];

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_fire   = r_ovalid && bus.out_ready;
    assign w_last   = (r_cnt == CW'(NCYC - 1));

    // One inverse S-box per lane, addressed by the current chunk.
    genvar gl;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            assign w_lane_in[gl] =
                r_work[127 - 8 * (int'(r_cnt) * LANES + gl) -: 8];
            assign w_lane_out[gl] = inv_sbox(w_lane_in[gl]);
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_BUSY;
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (w_fire) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Working state, chunk counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_work   <= '0;
            r_out    <= '0;
            r_ovalid <= 1'b0;
            r_key    <= '0;
        end else begin
            if (w_accept) begin
                r_work <= bus.in_data;
                r_cnt  <= '0;
`ifdef INV_SUB_ADDKEY_EN
                r_key  <= round_key;
`endif
            end
            if (r_state == S_BUSY) begin
                for (int l = 0; l < LANES; l++) begin
                    r_work[127 - 8 * (int'(r_cnt) * LANES + l) -: 8]
                        <= w_lane_out[l];
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (r_state == S_DONE && !r_ovalid) begin
                r_ovalid <= 1'b1;
                r_out    <= r_work ^ r_key;
            end
            if (w_fire) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_ovalid;
    assign bus.out_data  = r_out;
    assign busy          = w_busy;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomized bench for inv_sub_bytes_seq against a GF(2^8) reference.
// Define INV_SUB_ADDKEY_EN to exercise the fused AddRoundKey build.
module tb_inv_sub_bytes_seq;

    localparam int LANES = 4;
    localparam int NCYC  = 16 / LANES;
`ifdef INV_SUB_ADDKEY_EN
    localparam bit HAS_KEY = 1'b1;
`else
    localparam bit HAS_KEY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         busy;
    logic [127:0] key_drv = '0;

    inv_sub_bytes_seq_if u_if ();

    inv_sub_bytes_seq #(.LANES(LANES)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (u_if),
`ifdef INV_SUB_ADDKEY_EN
        .round_key (key_drv),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] isb [256];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from the field inverse and affine map, then invert it.
    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                ^ rotl(inv, 4) ^ 8'h63;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_out(input logic [127:0] d,
                                             input logic [127:0] k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = isb[d[127 - 8 * i -: 8]];
        end
        if (HAS_KEY) r = r ^ k;
        return r;
    endfunction

    // Send one block, wait for the result, optionally stall and poke.
    task automatic do_block(input logic [127:0] d, input logic [127:0] k,
                            input logic [127:0] exp, input int hold,
                            input bit poke);
        int lat;
        chk("idle_ready", u_if.in_ready, 1'b1);
        u_if.in_data   = d;
        key_drv        = k;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_data  = {4{$urandom()}};
        key_drv       = {4{$urandom()}};
        chk("busy_hi", busy, 1'b1);
        lat = 0;
        while (!u_if.out_valid && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), 128'(NCYC + 1));
        chk("out_data", u_if.out_data, exp);
        chk("no_pass", u_if.in_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            u_if.in_valid = poke && (h == 0);
            u_if.in_data  = {4{$urandom()}};
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", u_if.out_valid, 1'b1);
            chk("hold_data", u_if.out_data, exp);
            chk("hold_ready", u_if.in_ready, 1'b0);
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", u_if.out_valid, 1'b0);
        chk("drain_ready", u_if.in_ready, 1'b1);
        u_if.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] k;
        logic         seen;
        build_model();
        u_if.in_data   = '0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", u_if.in_ready, 1'b1);
        chk("rst_valid", u_if.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", u_if.out_data, 128'h0);

        do_block(128'h0, 128'h0, {16{8'h52}}, 0, 1'b0);

        do_block(128'h63017CFF_00000000_00000000_000000FF, 128'h0,
                 128'h0009017D_52525252_52525252_5252527D, 10, 1'b1);

        do_block(128'h7a9f102789d5f50b2beffd9f3dca4ea7, 128'h0,
                 128'hbd6e7c3df2b5779e0b61216e8b10b689, 0, 1'b0);

        // Abort a block with reset in its second BUSY cycle.
        u_if.in_data  = {4{$urandom()}};
        u_if.in_valid = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", u_if.out_valid, 1'b0);
        chk("abort_ready", u_if.in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_data", u_if.out_data, 128'h0);
        seen = 1'b0;
        repeat (NCYC + 4) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if.out_valid) seen = 1'b1;
        end
        chk("abort_quiet", seen, 1'b0);
        u_if.out_ready = 1'b0;
        do_block({16{8'h63}}, 128'h0, 128'h0, 0, 1'b0);

        k = {128{1'b1}};
        do_block(128'h0, k, HAS_KEY ? {16{8'hAD}} : {16{8'h52}}, 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            int hold;
            d    = {$urandom(), $urandom(), $urandom(), $urandom()};
            k    = {$urandom(), $urandom(), $urandom(), $urandom()};
            hold = $urandom_range(0, 3);
            do_block(d, k, ref_out(d, k), hold, hold > 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
